pc_branch_sequencer: RTL and testbench

- Program-counter and branch-resolution stage of the KGP-RISC core, directly downstream of the branch condition evaluator.
- Holds the architectural PC and captures a decoded branch or jump request.
- Samples the evaluator's single-bit taken result one cycle later, then redirects or advances the PC.
- Drives fetch-flush and link-register write-back.

---
 rtl/pc_branch_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_branch_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_sequencer.sv
// PC and branch-resolution stage: captures a branch request, resolves it one cycle later
// from cond_y, then redirects with a fetch flush or falls through. Optional counters: PC_BRANCH_STATS_EN.
module pc_branch_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              PC_STEP      = 4,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_req,
    input  logic            br_uncond,
    input  logic            br_link,
    input  logic [XLEN-1:0] br_target,
    input  logic            cond_y,
    output logic [XLEN-1:0] pc,
    output logic            flush,
    output logic            redirect,
    output logic            link_we,
    output logic [XLEN-1:0] link_data,
    output logic            misalign,
    output logic            busy
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     nottaken_cnt
`endif
);

    typedef enum logic [1:0] {RUN, RESOLVE, FLUSH} state_t;

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [XLEN-1:0] pc_nxt, link_data_nxt, pc_inc;
    logic            flush_nxt, redirect_nxt, link_we_nxt, misalign_nxt;
    logic            capture, taken, taken_evt, nottaken_evt;

    logic [XLEN-1:0] cap_target, cap_ret;
    logic            cap_uncond, cap_link;

    assign pc_inc = pc + STEP;
    assign taken  = cap_uncond | cond_y;
    assign busy   = (state != RUN);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cnt_nxt       = cnt;
        flush_nxt     = flush;
        redirect_nxt  = 1'b0;
        link_we_nxt   = 1'b0;
        misalign_nxt  = 1'b0;
        link_data_nxt = link_data;
        capture       = 1'b0;
        taken_evt     = 1'b0;
        nottaken_evt  = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (br_req) begin
                        capture   = 1'b1;
                        state_nxt = RESOLVE;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            RESOLVE: begin
                if (!stall) begin
                    if (taken) begin
                        pc_nxt       = {cap_target[XLEN-1:2], 2'b00};
                        redirect_nxt = 1'b1;
                        flush_nxt    = 1'b1;
                        misalign_nxt = |cap_target[1:0];
                        link_we_nxt  = cap_link;
                        if (cap_link)
                            link_data_nxt = cap_ret;
                        cnt_nxt      = FLUSH_LOAD;
                        state_nxt    = FLUSH;
                        taken_evt    = 1'b1;
                    end else begin
                        pc_nxt       = cap_ret;
                        state_nxt    = RUN;
                        nottaken_evt = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // The flush window is time-based, so stall only freezes the PC here.
                if (!stall)
                    pc_nxt = pc_inc;
                if (cnt == 4'd0) begin
                    state_nxt = RUN;
                    flush_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= 4'd0;
            pc        <= RESET_PC;
            flush     <= 1'b0;
            redirect  <= 1'b0;
            link_we   <= 1'b0;
            link_data <= '0;
            misalign  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pc        <= pc_nxt;
            flush     <= flush_nxt;
            redirect  <= redirect_nxt;
            link_we   <= link_we_nxt;
            link_data <= link_data_nxt;
            misalign  <= misalign_nxt;
        end
    end

    // Captured branch operands are pure data and only meaningful in RESOLVE.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_target <= br_target;
            cap_uncond <= br_uncond;
            cap_link   <= br_link;
            cap_ret    <= pc_inc;
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt    <= 16'd0;
            nottaken_cnt <= 16'd0;
        end else begin
            if (taken_evt && taken_cnt != 16'hFFFF)
                taken_cnt <= taken_cnt + 16'd1;
            if (nottaken_evt && nottaken_cnt != 16'hFFFF)
                nottaken_cnt <= nottaken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Self-checking bench for pc_branch_sequencer: vector table with a scoreboard queue,
// plus hand-written wrap-around and asynchronous-reset-during-flush sequences.
module tb_pc_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, stall, br_req, br_uncond, br_link, cond_y;
    logic [31:0] br_target;
    logic [31:0] pc, link_data;
    logic        flush, redirect, link_we, misalign, busy;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_cnt, nottaken_cnt;
`endif

    always #5 clk = ~clk;

    pc_branch_sequencer #(
        .XLEN(32), .RESET_PC(32'h0), .PC_STEP(4), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_req(br_req),
        .br_uncond(br_uncond), .br_link(br_link), .br_target(br_target),
        .cond_y(cond_y), .pc(pc), .flush(flush), .redirect(redirect),
        .link_we(link_we), .link_data(link_data), .misalign(misalign),
        .busy(busy)
`ifdef PC_BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
    );

    typedef struct {
        logic        st, rq, un, lk;
        logic [31:0] tgt;
        logic        cy;
        logic [31:0] pc;
        logic        fl, rd, lw;
        logic [31:0] ld;
        logic        ms, by;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        fl, rd, lw;
        logic [31:0] ld;
        logic        ms, by;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rq, input logic un, input logic lk,
                                input logic [31:0] tgt, input logic cy, input logic [31:0] p,
                                input logic fl, input logic rd, input logic lw,
                                input logic [31:0] ld, input logic ms, input logic by);
        vec_t v;
        v.st = st; v.rq = rq; v.un = un; v.lk = lk; v.tgt = tgt; v.cy = cy;
        v.pc = p; v.fl = fl; v.rd = rd; v.lw = lw; v.ld = ld; v.ms = ms; v.by = by;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        stall = v.st; br_req = v.rq; br_uncond = v.un; br_link = v.lk;
        br_target = v.tgt; cond_y = v.cy;
        e.pc = v.pc; e.fl = v.fl; e.rd = v.rd; e.lw = v.lw; e.ld = v.ld; e.ms = v.ms; e.by = v.by;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s.sb: got empty scoreboard, expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".pc"},        pc,               e.pc);
            check({tag, ".flush"},     {31'd0, flush},   {31'd0, e.fl});
            check({tag, ".redirect"},  {31'd0, redirect},{31'd0, e.rd});
            check({tag, ".link_we"},   {31'd0, link_we}, {31'd0, e.lw});
            check({tag, ".link_data"}, link_data,        e.ld);
            check({tag, ".misalign"},  {31'd0, misalign},{31'd0, e.ms});
            check({tag, ".busy"},      {31'd0, busy},    {31'd0, e.by});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           st rq un lk target        cy  pc            fl rd lw ld            ms by
        // free run from reset
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h004,      0,0,0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h008,      0,0,0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h00C,      0,0,0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h010,      0,0,0,32'h0,       0,0));
        // conditional taken at 0x10
        vecs.push_back(mk(0,1,0,0,32'h40,       0, 32'h010,      0,0,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        1, 32'h040,      1,1,0,32'h0,       0,1));
        vecs.push_back(mk(0,1,1,1,32'h999,      1, 32'h044,      1,0,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h048,      0,0,0,32'h0,       0,0));
        // conditional not taken
        vecs.push_back(mk(0,1,0,1,32'h80,       0, 32'h048,      0,0,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h04C,      0,0,0,32'h0,       0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h050,      0,0,0,32'h0,       0,0));
        // unconditional jump ignores cond_y=0
        vecs.push_back(mk(0,1,1,0,32'h100,      0, 32'h050,      0,0,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h100,      1,1,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h104,      1,0,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h108,      0,0,0,32'h0,       0,0));
        // jump-and-link to misaligned target
        vecs.push_back(mk(0,1,1,1,32'h203,      0, 32'h108,      0,0,0,32'h0,       0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h200,      1,1,1,32'h10C,     1,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h204,      1,0,0,32'h10C,     0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h208,      0,0,0,32'h10C,     0,0));
        // stall in RESOLVE with cond_y toggling
        vecs.push_back(mk(0,1,0,0,32'h300,      0, 32'h208,      0,0,0,32'h10C,     0,1));
        vecs.push_back(mk(1,0,0,0,32'h0,        1, 32'h208,      0,0,0,32'h10C,     0,1));
        vecs.push_back(mk(1,0,0,0,32'h0,        0, 32'h208,      0,0,0,32'h10C,     0,1));
        vecs.push_back(mk(1,0,0,0,32'h0,        1, 32'h208,      0,0,0,32'h10C,     0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        1, 32'h300,      1,1,0,32'h10C,     0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h304,      1,0,0,32'h10C,     0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h308,      0,0,0,32'h10C,     0,0));
        // stall beats br_req in RUN
        vecs.push_back(mk(1,1,1,0,32'h500,      1, 32'h308,      0,0,0,32'h10C,     0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h30C,      0,0,0,32'h10C,     0,0));
        // stall during FLUSH: pc holds, flush window still expires
        vecs.push_back(mk(0,1,1,0,32'h400,      0, 32'h30C,      0,0,0,32'h10C,     0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h400,      1,1,0,32'h10C,     0,1));
        vecs.push_back(mk(1,0,0,0,32'h0,        0, 32'h400,      1,0,0,32'h10C,     0,1));
        vecs.push_back(mk(1,0,0,0,32'h0,        0, 32'h400,      0,0,0,32'h10C,     0,0));
        vecs.push_back(mk(0,0,0,0,32'h0,        0, 32'h404,      0,0,0,32'h10C,     0,0));

        rst_n = 1'b0; stall = 0; br_req = 0; br_uncond = 0; br_link = 0;
        br_target = '0; cond_y = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.pc",        pc,                 32'h0);
        check("reset.flush",     {31'd0, flush},     32'd0);
        check("reset.redirect",  {31'd0, redirect},  32'd0);
        check("reset.link_we",   {31'd0, link_we},   32'd0);
        check("reset.link_data", link_data,          32'h0);
        check("reset.misalign",  {31'd0, misalign},  32'd0);
        check("reset.busy",      {31'd0, busy},      32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // jump to the top of the address space, then wrap during the flush window
        apply(mk(0,1,1,0,32'hFFFF_FFFC,0, 32'h404,       0,0,0,32'h10C,0,1), "wrap0");
        apply(mk(0,0,0,0,32'h0,        0, 32'hFFFF_FFFC, 1,1,0,32'h10C,0,1), "wrap1");
        apply(mk(0,0,0,0,32'h0,        0, 32'h0000_0000, 1,0,0,32'h10C,0,1), "wrap2");

        // asynchronous reset in the middle of FLUSH takes effect without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.pc",        pc,                32'h0);
        check("areset.flush",     {31'd0, flush},    32'd0);
        check("areset.busy",      {31'd0, busy},     32'd0);
        check("areset.link_data", link_data,         32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(0,0,0,0,32'h0, 0, 32'h004, 0,0,0,32'h0,0,0), "post0");
        apply(mk(0,0,0,0,32'h0, 0, 32'h008, 0,0,0,32'h0,0,0), "post1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
